// File: rtl/pm32_pkg.sv
// Shared types and widths for the pm32 multiplier front end.
package pm32_pkg;
   localparam int OP_W        = 32;
   localparam int PROD_W      = 64;
   localparam int TIMEOUT_DEF = 100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;
endpackage

// File: rtl/pm32_seq_if.sv
// Request, result and multiplier-side signals of pm32_seq.
// master = environment (requester, consumer, multiplier); slave = pm32_seq.
interface pm32_seq_if
   import pm32_pkg::*;
#(
   parameter int TAG_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [OP_W-1:0]   req_mc;
   logic [OP_W-1:0]   req_mp;
   logic [TAG_W-1:0]  req_tag;

   logic              res_valid;
   logic              res_ready;
   logic [PROD_W-1:0] res_p;
   logic [TAG_W-1:0]  res_tag;
   logic              res_err;

   logic              mul_start;
   logic [OP_W-1:0]   mul_mc;
   logic [OP_W-1:0]   mul_mp;
   logic [PROD_W-1:0] mul_p;
   logic              mul_done;

   modport master (
      output req_valid, req_mc, req_mp, req_tag, res_ready, mul_p, mul_done,
      input  req_ready, res_valid, res_p, res_tag, res_err, mul_start, mul_mc, mul_mp
   );

   modport slave (
      input  req_valid, req_mc, req_mp, req_tag, res_ready, mul_p, mul_done,
      output req_ready, res_valid, res_p, res_tag, res_err, mul_start, mul_mc, mul_mp
   );
endinterface

// File: rtl/pm32_seq_sync_fifo.sv
// Synchronous FIFO with registered occupancy; head is the oldest entry.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/pm32_seq.sv
// Queues multiply requests, runs them one at a time on pm32 and returns tagged products.
// state | meaning
// IDLE  | nothing in flight, waiting for a queued request
// ISSUE | one-cycle start pulse, operands valid, head popped
// WAIT  | multiplier running; watchdog counting
// OUT   | result presented until consumer accepts it
module pm32_seq
   import pm32_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic       clk,
   input logic       rst,
   pm32_seq_if.slave bus
);
   localparam int ENT_W = TAG_W + 2*OP_W;
   localparam int WD_W  = $clog2(TIMEOUT);

   state_t            state, state_nxt;
   logic              fifo_full, fifo_empty, push, pop, load;
   logic [ENT_W-1:0]  head;
   logic [OP_W-1:0]   mc_q, mp_q;
   logic [TAG_W-1:0]  cur_tag;
   logic [WD_W-1:0]   wd;
   logic              armed, done_ok, timeout, res_hs;
   logic              res_valid_q, res_err_q;
   logic [PROD_W-1:0] res_p_q;
   logic [TAG_W-1:0]  res_tag_q;

   sync_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({bus.req_tag, bus.req_mp, bus.req_mc}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );

   assign bus.req_ready = !fifo_full;
   assign push          = bus.req_valid && !fifo_full;
   assign pop           = (state == ISSUE);
   assign bus.mul_start = (state == ISSUE);
   assign bus.mul_mc    = mc_q;
   assign bus.mul_mp    = mp_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_p     = res_p_q;
   assign bus.res_tag   = res_tag_q;
   assign bus.res_err   = res_err_q;

   // done left high by the previous run only counts once it has been seen low
   assign done_ok = armed && bus.mul_done;
   assign timeout = (wd == WD_W'(TIMEOUT - 1));
   assign res_hs  = res_valid_q && bus.res_ready;
   assign load    = (state_nxt == ISSUE) && (state != ISSUE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (done_ok || timeout) state_nxt = OUT;
         OUT:     if (res_hs) state_nxt = fifo_empty ? IDLE : ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mc_q        <= '0;
         mp_q        <= '0;
         cur_tag     <= '0;
         wd          <= '0;
         armed       <= 1'b0;
         res_valid_q <= 1'b0;
         res_p_q     <= '0;
         res_tag_q   <= '0;
         res_err_q   <= 1'b0;
      end else begin
         if (load) begin
            mc_q    <= head[OP_W-1:0];
            mp_q    <= head[2*OP_W-1:OP_W];
            cur_tag <= head[ENT_W-1:2*OP_W];
         end
         case (state)
            ISSUE: begin
               armed <= 1'b0;
               wd    <= '0;
            end
            WAIT: begin
               if (done_ok) begin
                  res_p_q     <= bus.mul_p;
                  res_tag_q   <= cur_tag;
                  res_err_q   <= 1'b0;
                  res_valid_q <= 1'b1;
               end else begin
                  if (!bus.mul_done) armed <= 1'b1;
                  if (timeout) begin
                     res_p_q     <= '0;
                     res_tag_q   <= cur_tag;
                     res_err_q   <= 1'b1;
                     res_valid_q <= 1'b1;
                  end else begin
                     wd <= wd + 1'b1;
                  end
               end
            end
            OUT:     if (res_hs) res_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pm32_seq.sv
// Scoreboard bench for pm32_seq with a behavioural pm32 model (stale-done and hang modes).
module tb_pm32_seq;
   localparam int RUN     = 66;
   localparam int TIMEOUT = 100;

   typedef struct packed {
      logic [63:0] p;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sb[$];

   pm32_seq_if #(.TAG_W(4)) bus ();

   pm32_seq #(.DEPTH(4), .TAG_W(4), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // pm32 model: done falls at start (or 2 cycles later when stale), rises after RUN cycles
   logic        md = 1'b0;
   logic [63:0] mprod = '0;
   logic        busy = 1'b0, stale_run = 1'b0, hang_run = 1'b0;
   int          run_cnt = 0;
   int          starts = 0;
   int          stale_idx = -1;
   int          hang_idx = -1;

   assign bus.mul_done = md;
   assign bus.mul_p    = mprod;

   always @(posedge clk) begin
      if (bus.mul_start) begin
         stale_run <= (starts == stale_idx);
         hang_run  <= (starts == hang_idx);
         if (starts != stale_idx) md <= 1'b0;
         busy    <= 1'b1;
         run_cnt <= 0;
         starts  <= starts + 1;
      end else if (busy) begin
         run_cnt <= run_cnt + 1;
         if (stale_run && run_cnt == 1) md <= 1'b0;
         if (run_cnt == RUN-1 && !hang_run) begin
            md    <= 1'b1;
            mprod <= $signed({{32{bus.mul_mc[31]}}, bus.mul_mc}) *
                     $signed({{32{bus.mul_mp[31]}}, bus.mul_mp});
            busy  <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // monitor: pops the scoreboard on each accepted result; checks hold stability under backpressure
   int          last_start_cyc = 0;
   int          valid_delta = 0;
   logic        prev_valid = 1'b0, prev_hold = 1'b0;
   logic [63:0] held_p;
   logic [3:0]  held_tag;
   logic        held_err;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_hold  = 1'b0;
      end else begin
         if (bus.mul_start) last_start_cyc = cyc;
         if (bus.res_valid && !prev_valid) valid_delta = cyc - last_start_cyc;
         if (prev_hold) begin
            check("hold_valid", 64'(bus.res_valid), 64'd1);
            check("hold_p", bus.res_p, held_p);
            check("hold_tag", 64'(bus.res_tag), 64'(held_tag));
            check("hold_err", 64'(bus.res_err), 64'(held_err));
         end
         if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_result_tag", 64'(bus.res_tag), 64'hDEAD);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("res_p", bus.res_p, e.p);
               check("res_tag", 64'(bus.res_tag), 64'(e.tag));
               check("res_err", 64'(bus.res_err), 64'(e.err));
            end
         end
         prev_hold  = bus.res_valid && !bus.res_ready;
         held_p     = bus.res_p;
         held_tag   = bus.res_tag;
         held_err   = bus.res_err;
         prev_valid = bus.res_valid;
      end
   end

   task automatic push(input logic [31:0] mc, input logic [31:0] mp, input logic [3:0] tag,
                       input logic [63:0] ep, input logic ee);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("push_ready_timeout", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_mc    = mc;
      bus.req_mp    = mp;
      bus.req_tag   = tag;
      sb.push_back('{p: ep, tag: tag, err: ee});
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_sb(input int left, input int budget);
      int n;
      n = 0;
      while (sb.size() > left && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > left) check("result_wait_timeout", 64'(sb.size()), 64'(left));
   endtask

   initial begin
      int s0, n;
      bus.req_valid = 1'b0;
      bus.req_mc    = '0;
      bus.req_mp    = '0;
      bus.req_tag   = '0;
      bus.res_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_res_valid", 64'(bus.res_valid), 64'd0);
      check("rst_req_ready", 64'(bus.req_ready), 64'd1);
      check("rst_mul_start", 64'(bus.mul_start), 64'd0);
      check("rst_mul_mc", 64'(bus.mul_mc), 64'd0);
      check("rst_mul_mp", 64'(bus.mul_mp), 64'd0);
      check("rst_res_p", bus.res_p, 64'd0);
      check("rst_res_tag", 64'(bus.res_tag), 64'd0);
      check("rst_res_err", 64'(bus.res_err), 64'd0);
      rst = 1'b0;

      // single request
      s0 = starts;
      push(32'd3, -32'sd5, 4'd1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
      wait_sb(0, 500);
      check("single_start_count", 64'(starts - s0), 64'd1);
      check("single_latency", 64'(valid_delta), 64'(RUN + 2));

      // back-to-back pushes; five so four are queued behind the one in flight
      push(32'd7, 32'd6, 4'd2, 64'd42, 1'b0);
      push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 64'd1, 1'b0);
      push(32'h8000_0000, 32'h8000_0000, 4'd4, 64'h4000_0000_0000_0000, 1'b0);
      push(32'd0, 32'd123, 4'd5, 64'd0, 1'b0);
      push(32'd5, -32'sd7, 4'd6, 64'hFFFF_FFFF_FFFF_FFDD, 1'b0);
      @(negedge clk);
      check("full_req_ready", 64'(bus.req_ready), 64'd0);
      wait_sb(0, 2000);

      // backpressure
      bus.res_ready = 1'b0;
      push(32'd9, 32'd9, 4'd7, 64'd81, 1'b0);
      push(-32'sd2, 32'd3, 4'd8, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
      n = 0;
      while (!bus.res_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("bp_first_valid", 64'(bus.res_valid), 64'd1);
      s0 = starts;
      repeat (200) @(negedge clk);
      check("bp_no_restart", 64'(starts), 64'(s0));
      check("bp_queue_kept", 64'(sb.size()), 64'd2);
      bus.res_ready = 1'b1;
      wait_sb(0, 500);
      check("bp_start_after", 64'(starts - s0), 64'd1);

      // stale done from the previous run
      stale_idx = starts;
      push(32'd100, -32'sd3, 4'd9, 64'hFFFF_FFFF_FFFF_FED4, 1'b0);
      wait_sb(0, 500);
      check("stale_latency", 64'(valid_delta), 64'(RUN + 2));

      // hung multiplier, then a normal request behind it
      hang_idx = starts;
      push(32'd2, 32'd2, 4'd10, 64'd0, 1'b1);
      push(32'd4, -32'sd4, 4'd11, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
      wait_sb(1, 500);
      check("timeout_latency", 64'(valid_delta), 64'(TIMEOUT + 1));
      wait_sb(0, 500);

      // reset while a run is in flight with two requests queued
      s0 = starts;
      push(32'd5, 32'd5, 4'd12, 64'd25, 1'b0);
      push(32'd6, 32'd6, 4'd13, 64'd36, 1'b0);
      push(32'd7, 32'd7, 4'd14, 64'd49, 1'b0);
      repeat (5) @(negedge clk);
      check("mid_started", 64'(starts - s0), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
      check("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
      check("mid_rst_mul_start", 64'(bus.mul_start), 64'd0);
      s0 = starts;
      repeat (300) @(negedge clk);
      check("mid_rst_no_issue", 64'(starts), 64'(s0));
      push(32'd8, 32'd8, 4'd15, 64'd64, 1'b0);
      wait_sb(0, 500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pm32_seq.md
Name: pm32_seq

Overview:
- Request/response front end for the pm32 serial signed 32x32 multiplier.
- Buffers operand requests in a small FIFO and issues them one at a time to the multiplier with a single-cycle start pulse.
- Holds mc/mp stable for the whole run, detects completion on the level-type done, and returns the tagged 64-bit product over a valid/ready result port.
- Adds a watchdog so a hung multiplier yields an error-flagged result instead of a deadlock.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, >=2)
- TAG_W, 4, width of the request tag returned with each result
- TIMEOUT, 100, max cycles in WAIT before an error result is produced (must exceed 66)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request FIFO can accept
- req_mc  in  32  multiplicand, signed
- req_mp  in  32  multiplier, signed
- req_tag  in  TAG_W  caller tag
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_p  out  64  signed product
- res_tag  out  TAG_W  tag of the originating request
- res_err  out  1  result produced by timeout; res_p is 0
- mul_start  out  1  start pulse to the multiplier
- mul_mc  out  32  multiplicand to the multiplier
- mul_mp  out  32  multiplier operand to the multiplier
- mul_p  in  64  multiplier product
- mul_done  in  1  multiplier done level

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high (ports clk, rst). All state updates on the rising edge of clk.
  - rst=1 at an edge: FIFO emptied; state=IDLE; mul_start=0; mul_mc=mul_mp=0; res_valid=0; res_p=0; res_tag=0; res_err=0; watchdog=0; armed=0.
  - Reset mid-operation drops any in-flight request and any queued requests without producing a result.
- Request side:
  - req_ready = !fifo_full, registered count only; there is no bypass when a pop happens in the same cycle.
  - Push on req_valid && req_ready. A push and a pop in the same cycle are both honoured.
- States:
  - IDLE: if FIFO non-empty, go to ISSUE.
  - ISSUE (exactly 1 cycle):
    - mul_start=1.
    - mul_mc/mul_mp/cur_tag are loaded from the FIFO head at the entry edge, so they are valid while mul_start=1.
    - Pop the FIFO; clear armed and watchdog; go to WAIT.
  - WAIT:
    - mul_start=0; mul_mc/mul_mp held constant. The multiplier reads mc on every run cycle.
    - armed is set the first cycle mul_done=0 is observed. Completion requires armed && mul_done, so the stale done from the previous run is ignored.
    - On completion: res_p<=mul_p, res_tag<=cur_tag, res_err<=0, res_valid<=1, go to OUT.
    - The watchdog increments each WAIT cycle. When it reaches TIMEOUT-1 without completion: res_p<=0, res_err<=1, res_tag<=cur_tag, res_valid<=1, go to OUT.
  - OUT:
    - res_* are held stable while res_valid && !res_ready.
    - On the handshake: res_valid<=0, then go to ISSUE if the FIFO is non-empty in that cycle, else IDLE.
- Ordering and throughput:
  - At most one request is in flight; results return in request order.
  - Latency from push into an empty, idle block to res_valid is 3 + multiplier run length (~66) cycles.
- Width rules:
  - Product is passed through unchanged, signed two's complement. No truncation or extension.
- Simultaneous events:
  - completion and timeout in the same cycle: completion wins (res_err=0).
  - req push while the FIFO is full: ignored, because req_ready=0.

Decomposition:
- Package pm32_pkg:
  - state enum {IDLE, ISSUE, WAIT, OUT} (2 bits)
  - localparams OP_W=32, PROD_W=64
  - default TIMEOUT
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Stores {tag, mp, mc}.
  - Interface: push/pop/full/empty/head, synchronous active-high rst, registered count.
- Top-level content: FSM, watchdog, armed flag, and result register.

Test Plan:
- Single request mc=3, mp=-5, tag=1 with real pm32 attached -> exactly one mul_start pulse; res_p=64'hFFFF_FFFF_FFFF_FFF1, res_tag=1, res_err=0.
- Back-to-back pushes:
  - Requests: (7,6,t2), (-1,-1,t3), (32'h8000_0000,32'h8000_0000,t4), (0,123,t5), with res_ready=1.
  - Expected products: 42; 1; 64'h4000_0000_0000_0000; 0.
  - Tags return in order; req_ready=0 when 4 entries are held.
- Backpressure: hold res_ready=0 for 200 cycles after the first result -> res_* stable; no second mul_start until the handshake; queued requests are retained.
- Stale done: the multiplier model keeps done=1 from the previous run for 2 cycles after start -> no premature result; result is captured only after done falls and rises.
- Timeout: the multiplier model never raises done -> res_valid exactly TIMEOUT cycles after the WAIT entry, with res_err=1, res_p=0 and the correct tag; the next queued request is then issued.
- Reset mid-run: assert rst for 1 cycle in WAIT with 2 entries queued -> next cycle res_valid=0, req_ready=1, mul_start=0; no result is ever produced for the dropped requests.
